ladowarka_programu: RTL

Serial program loader for the PLC processor: the write side of the program store that the processor's program counter reads. It accepts a framed byte stream (sync, start address, pair count, opcode/operand pairs, XOR checksum) and writes each pair into the dual-field program RAM. While a frame is in flight it holds the processor in reset. On a good frame it releases the processor. On a bad frame or a stall it reports an error and keeps the processor held.

---
 rtl/ladowarka_programu_pkg.sv | 23 ++
 rtl/ladowarka_programu_licznik_czasu.sv | 39 +++
 rtl/ladowarka_programu.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ladowarka_programu_pkg.sv
// rtl/ladowarka_programu_pkg.sv - shared types and constants for the serial program loader
//
// Holds the loader state enum, the default frame sync byte and the address/data
// widths shared with the program RAM and the program counter.

package ladowarka_programu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SYNC_DOMYSLNY = 8'hA5;

  typedef enum logic [2:0] {
    BEZCZYNNY,
    ADRES,
    LICZBA,
    OPKOD,
    OPERAND,
    ZAPIS,
    SUMA
  } stan_t;

endpackage

// File: rtl/ladowarka_programu_licznik_czasu.sv
// rtl/ladowarka_programu_licznik_czasu.sv - reloadable inactivity down-counter with terminal pulse
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   przeladuj  - reload to TIMEOUT (has priority over counting and suppresses koniec)
//   aktywny    - count down this cycle
//   koniec     - high in the TIMEOUT-th consecutive active cycle without a reload;
//                the owner acts on it at the closing edge of that cycle

module licznik_czasu #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic przeladuj,
  input  logic aktywny,
  output logic koniec
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] START = W'(TIMEOUT);

  logic [W-1:0] licznik;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      licznik <= START;
    end else if (przeladuj) begin
      licznik <= START;
    end else if (aktywny && licznik != '0) begin
      licznik <= licznik - 1'b1;
    end
  end

  // A reload in the same cycle means a byte arrived in time, so it wins.
  assign koniec = aktywny && !przeladuj && (licznik == W'(1));

endmodule

// File: rtl/ladowarka_programu.sv
// rtl/ladowarka_programu.sv - framed serial loader writing opcode/operand pairs into program RAM
//
// Frame: SYNC, start address, pair count, {opcode, operand} x count, XOR checksum
// of every byte after SYNC. The processor is held in reset while a frame is in
// flight and released only after a frame with a correct checksum.
//
// Ports:
//   clk, rst       - clock (rising edge), asynchronous active-low reset
//   bajt_in        - incoming byte
//   bajt_valid     - bajt_in valid
//   bajt_ready     - loader accepts a byte (low only during the write cycle)
//   wr_en          - one-cycle program RAM write strobe
//   wr_addr        - program address (address counter)
//   wr_dane        - opcode field
//   wr_wartosc     - operand field
//   cpu_wstrzymaj  - holds the processor while high
//   gotowe         - one-cycle pulse on a frame with a correct checksum
//   blad           - sticky error: checksum mismatch or timeout, cleared by next SYNC

module ladowarka_programu
  import ladowarka_programu_pkg::*;
#(
  parameter int                TIMEOUT = 1000,
  parameter logic [DATA_W-1:0] SYNC    = SYNC_DOMYSLNY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bajt_in,
  input  logic              bajt_valid,
  output logic              bajt_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_dane,
  output logic [DATA_W-1:0] wr_wartosc,
  output logic              cpu_wstrzymaj,
  output logic              gotowe,
  output logic              blad
);

  stan_t             stan, stan_nast;
  logic              akcept;
  logic              koniec;
  logic              czas_stoi;
  logic [ADDR_W-1:0] adres;
  logic [DATA_W-1:0] licz_par;
  logic [DATA_W-1:0] suma;

  assign akcept  = bajt_valid && bajt_ready;
  assign wr_addr = adres;

  // The inactivity timer only runs inside a frame, and not in the write cycle
  // where the loader itself refuses bytes.
  assign czas_stoi = (stan == BEZCZYNNY) || (stan == ZAPIS);

  licznik_czasu #(.TIMEOUT(TIMEOUT)) u_licznik_czasu (
    .clk       (clk),
    .rst       (rst),
    .przeladuj (akcept || czas_stoi),
    .aktywny   (!czas_stoi),
    .koniec    (koniec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stan <= BEZCZYNNY;
    end else begin
      stan <= stan_nast;
    end
  end

  always_comb begin
    stan_nast = stan;
    case (stan)
      BEZCZYNNY: if (akcept && bajt_in == SYNC) stan_nast = ADRES;
      ADRES:     if (akcept) stan_nast = LICZBA;
      LICZBA:    if (akcept) stan_nast = (bajt_in == '0) ? SUMA : OPKOD;
      OPKOD:     if (akcept) stan_nast = OPERAND;
      OPERAND:   if (akcept) stan_nast = ZAPIS;
      // licz_par still holds the pre-decrement value here
      ZAPIS:     stan_nast = (licz_par == DATA_W'(1)) ? SUMA : OPKOD;
      SUMA:      if (akcept) stan_nast = BEZCZYNNY;
      default:   stan_nast = BEZCZYNNY;
    endcase
    if (koniec) begin
      stan_nast = BEZCZYNNY;
    end
  end

  always_comb begin
    wr_en      = (stan == ZAPIS);
    bajt_ready = (stan != ZAPIS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adres         <= '0;
      licz_par      <= '0;
      suma          <= '0;
      wr_dane       <= '0;
      wr_wartosc    <= '0;
      cpu_wstrzymaj <= 1'b0;
      gotowe        <= 1'b0;
      blad          <= 1'b0;
    end else begin
      gotowe <= 1'b0;
      case (stan)
        BEZCZYNNY: begin
          if (akcept && bajt_in == SYNC) begin
            cpu_wstrzymaj <= 1'b1;
            blad          <= 1'b0;
            suma          <= '0;
          end
        end
        ADRES: begin
          if (akcept) begin
            adres <= bajt_in;
            suma  <= suma ^ bajt_in;
          end
        end
        LICZBA: begin
          if (akcept) begin
            licz_par <= bajt_in;
            suma     <= suma ^ bajt_in;
          end
        end
        OPKOD: begin
          if (akcept) begin
            wr_dane <= bajt_in;
            suma    <= suma ^ bajt_in;
          end
        end
        OPERAND: begin
          if (akcept) begin
            wr_wartosc <= bajt_in;
            suma       <= suma ^ bajt_in;
          end
        end
        ZAPIS: begin
          adres    <= adres + 1'b1;
          licz_par <= licz_par - 1'b1;
        end
        SUMA: begin
          if (akcept) begin
            if (bajt_in == suma) begin
              gotowe        <= 1'b1;
              cpu_wstrzymaj <= 1'b0;
            end else begin
              blad <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Timeout leaves the processor held; pairs already written stay in RAM.
      if (koniec) begin
        blad <= 1'b1;
      end
    end
  end

endmodule
